// File: rtl/load_align_unit.sv
// Load alignment unit: accepts one load at a time, fetches one or two aligned
// bus words, merges them, extracts the addressed field and sign/zero-extends it.

package load_align_pkg;
    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;
endpackage

module load_align_unit
    import load_align_pkg::*;
#(
    parameter int DATA_W         = 64,
    parameter int ADDR_W         = 64,
    parameter bit ALLOW_MISALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  msize_t            req_msize,
    input  logic              req_unsigned,
    output logic              dreq_valid,
    output logic [ADDR_W-1:0] dreq_addr,
    input  logic              dresp_valid,
    input  logic [DATA_W-1:0] dresp_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_split,
    output logic              resp_err
);
    localparam int                BYTES     = DATA_W / 8;
    localparam int                OFF_W     = $clog2(BYTES);
    localparam logic [4:0]        BYTES_L   = 5'(BYTES);
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MSK = ~ADDR_W'(BYTES - 1);
    localparam bit                NO_DWORD  = (DATA_W == 32);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Access size in bytes.
    function automatic logic [3:0] size_bytes(input msize_t m);
        case (m)
            MSIZE1:  size_bytes = 4'd1;
            MSIZE2:  size_bytes = 4'd2;
            MSIZE4:  size_bytes = 4'd4;
            default: size_bytes = 4'd8;
        endcase
    endfunction

    // Keep the low n bytes of the shifted word and fill above with the sign bit.
    // A full-width field produces an all-ones mask, so signedness is irrelevant there.
    function automatic logic [DATA_W-1:0] extend(input logic [2*DATA_W-1:0] word,
                                                 input msize_t m, input logic uns);
        logic [6:0]        nbits;
        logic              sgn;
        logic [DATA_W-1:0] mask;
        nbits = {size_bytes(m), 3'b000};
        case (m)
            MSIZE1:  sgn = word[7];
            MSIZE2:  sgn = word[15];
            MSIZE4:  sgn = word[31];
            default: sgn = word[63];
        endcase
        sgn    = sgn & ~uns;
        mask   = ~({DATA_W{1'b1}} << nbits);
        extend = (word[DATA_W-1:0] & mask) | ({DATA_W{sgn}} & ~mask);
    endfunction

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    msize_t              msize_q;
    logic                uns_q;
    logic                cross_q;
    logic [DATA_W-1:0]   beat0_q;
    logic                req_ready_q, req_ready_d;
    logic                dreq_valid_q, dreq_valid_d;
    logic [ADDR_W-1:0]   dreq_addr_q, dreq_addr_d;
    logic                resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_data_q, resp_data_d;
    logic                resp_split_q, resp_split_d;
    logic                resp_err_q, resp_err_d;

    logic                capture_s;
    logic [OFF_W-1:0]    req_off_s;
    logic [3:0]          req_n_s;
    logic                req_cross_s;
    logic [ADDR_W-1:0]   cur_addr_s;
    logic [ADDR_W-1:0]   aligned_s;
    logic [DATA_W-1:0]   b0_s;
    logic [DATA_W-1:0]   b1_s;
    logic [2*DATA_W-1:0] merged_s;
    logic [DATA_W-1:0]   ext_s;

    // Request geometry, address alignment and beat merge.
    always_comb begin
        req_off_s   = req_addr[OFF_W-1:0];
        req_n_s     = size_bytes(req_msize);
        req_cross_s = (5'(req_off_s) + 5'(req_n_s)) > BYTES_L;
        // Before capture the live request address is used; afterwards the latched one.
        cur_addr_s  = (state_q == IDLE) ? req_addr : addr_q;
        aligned_s   = cur_addr_s & ALIGN_MSK;
        // The beat arriving this cycle is merged directly so the result registers with it.
        b0_s        = (state_q == BEAT0) ? dresp_data : beat0_q;
        b1_s        = (state_q == BEAT1) ? dresp_data : {DATA_W{1'b0}};
        merged_s    = {b1_s, b0_s} >> {addr_q[OFF_W-1:0], 3'b000};
        ext_s       = extend(merged_s, msize_q, uns_q);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        resp_data_d  = resp_data_q;
        resp_split_d = resp_split_q;
        resp_err_d   = resp_err_q;
        capture_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    capture_s = 1'b1;
                    if ((req_msize == MSIZE8) && NO_DWORD) begin
                        state_d      = DONE;
                        resp_err_d   = 1'b1;
                        resp_data_d  = {DATA_W{1'b0}};
                        resp_split_d = 1'b0;
                    end else if (req_cross_s && !ALLOW_MISALIGN) begin
                        state_d      = DONE;
                        resp_err_d   = 1'b1;
                        resp_data_d  = {DATA_W{1'b0}};
                        resp_split_d = 1'b0;
                    end else begin
                        state_d = BEAT0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BEAT0: begin
                if (dresp_valid && cross_q) begin
                    state_d = BEAT1;
                end else if (dresp_valid) begin
                    state_d      = DONE;
                    resp_data_d  = ext_s;
                    resp_split_d = 1'b0;
                    resp_err_d   = 1'b0;
                end else begin
                    state_d = BEAT0;
                end
            end
            BEAT1: begin
                if (dresp_valid) begin
                    state_d      = DONE;
                    resp_data_d  = ext_s;
                    resp_split_d = 1'b1;
                    resp_err_d   = 1'b0;
                end else begin
                    state_d = BEAT1;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_data_d  = {DATA_W{1'b0}};
                    resp_split_d = 1'b0;
                    resp_err_d   = 1'b0;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d      = IDLE;
                resp_data_d  = {DATA_W{1'b0}};
                resp_split_d = 1'b0;
                resp_err_d   = 1'b0;
            end
        endcase

        req_ready_d  = (state_d == IDLE);
        dreq_valid_d = (state_d == BEAT0) || (state_d == BEAT1);
        resp_valid_d = (state_d == DONE);
        case (state_d)
            BEAT0:   dreq_addr_d = aligned_s;
            BEAT1:   dreq_addr_d = aligned_s + STEP;
            default: dreq_addr_d = {ADDR_W{1'b0}};
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b0;
            dreq_valid_q <= 1'b0;
            dreq_addr_q  <= {ADDR_W{1'b0}};
            resp_valid_q <= 1'b0;
            resp_data_q  <= {DATA_W{1'b0}};
            resp_split_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            dreq_valid_q <= dreq_valid_d;
            dreq_addr_q  <= dreq_addr_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_split_q <= resp_split_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Request attributes latched at acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= {ADDR_W{1'b0}};
            msize_q <= MSIZE1;
            uns_q   <= 1'b0;
            cross_q <= 1'b0;
        end else if (capture_s) begin
            addr_q  <= req_addr;
            msize_q <= req_msize;
            uns_q   <= req_unsigned;
            cross_q <= req_cross_s;
        end
    end

    // First bus beat, kept for merging with the second beat of a split load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat0_q <= {DATA_W{1'b0}};
        end else if ((state_q == BEAT0) && dresp_valid) begin
            beat0_q <= dresp_data;
        end
    end

    assign req_ready  = req_ready_q;
    assign dreq_valid = dreq_valid_q;
    assign dreq_addr  = dreq_addr_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_split = resp_split_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: three instances (64-bit misaligned-capable,
// 64-bit misalign-rejecting, 32-bit misaligned-capable) share the stimulus.
module tb_load_align_unit;
    import load_align_pkg::*;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [63:0] req_addr;
    msize_t      req_msize;
    logic        req_unsigned;
    logic        dresp_valid;
    logic [63:0] dresp_data;
    logic        resp_ready;

    logic        a_req_ready, a_dreq_valid, a_resp_valid, a_resp_split, a_resp_err;
    logic [63:0] a_dreq_addr, a_resp_data;
    logic        b_req_ready, b_dreq_valid, b_resp_valid, b_resp_split, b_resp_err;
    logic [63:0] b_dreq_addr, b_resp_data;
    logic        c_req_ready, c_dreq_valid, c_resp_valid, c_resp_split, c_resp_err;
    logic [63:0] c_dreq_addr;
    logic [31:0] c_resp_data;

    int          sel;
    logic        s_req_ready, s_dreq_valid, s_resp_valid, s_resp_split, s_resp_err;
    logic [63:0] s_dreq_addr, s_resp_data;

    int checks;
    int errors;

    load_align_unit #(.DATA_W(64), .ADDR_W(64), .ALLOW_MISALIGN(1'b1)) u_a (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(a_req_ready),
        .req_addr(req_addr), .req_msize(req_msize), .req_unsigned(req_unsigned),
        .dreq_valid(a_dreq_valid), .dreq_addr(a_dreq_addr), .dresp_valid(dresp_valid),
        .dresp_data(dresp_data), .resp_valid(a_resp_valid), .resp_ready(resp_ready),
        .resp_data(a_resp_data), .resp_split(a_resp_split), .resp_err(a_resp_err));

    load_align_unit #(.DATA_W(64), .ADDR_W(64), .ALLOW_MISALIGN(1'b0)) u_b (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(b_req_ready),
        .req_addr(req_addr), .req_msize(req_msize), .req_unsigned(req_unsigned),
        .dreq_valid(b_dreq_valid), .dreq_addr(b_dreq_addr), .dresp_valid(dresp_valid),
        .dresp_data(dresp_data), .resp_valid(b_resp_valid), .resp_ready(resp_ready),
        .resp_data(b_resp_data), .resp_split(b_resp_split), .resp_err(b_resp_err));

    load_align_unit #(.DATA_W(32), .ADDR_W(64), .ALLOW_MISALIGN(1'b1)) u_c (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(c_req_ready),
        .req_addr(req_addr), .req_msize(req_msize), .req_unsigned(req_unsigned),
        .dreq_valid(c_dreq_valid), .dreq_addr(c_dreq_addr), .dresp_valid(dresp_valid),
        .dresp_data(dresp_data[31:0]), .resp_valid(c_resp_valid), .resp_ready(resp_ready),
        .resp_data(c_resp_data), .resp_split(c_resp_split), .resp_err(c_resp_err));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Route the selected instance's outputs to a common view.
    always_comb begin
        case (sel)
            1: begin
                s_req_ready = b_req_ready; s_dreq_valid = b_dreq_valid; s_dreq_addr = b_dreq_addr;
                s_resp_valid = b_resp_valid; s_resp_data = b_resp_data;
                s_resp_split = b_resp_split; s_resp_err = b_resp_err;
            end
            2: begin
                s_req_ready = c_req_ready; s_dreq_valid = c_dreq_valid; s_dreq_addr = c_dreq_addr;
                s_resp_valid = c_resp_valid; s_resp_data = {32'h0, c_resp_data};
                s_resp_split = c_resp_split; s_resp_err = c_resp_err;
            end
            default: begin
                s_req_ready = a_req_ready; s_dreq_valid = a_dreq_valid; s_dreq_addr = a_dreq_addr;
                s_resp_valid = a_resp_valid; s_resp_data = a_resp_data;
                s_resp_split = a_resp_split; s_resp_err = a_resp_err;
            end
        endcase
    end

    typedef struct {
        int          dut;
        msize_t      msize;
        logic [63:0] addr;
        logic        uns;
        logic [63:0] b0;
        logic [63:0] b1;
        logic [63:0] exp_data;
        logic        exp_split;
        logic        exp_err;
        int          exp_beats;
        logic [63:0] exp_a0;
        logic [63:0] exp_a1;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1; req_valid = 1'b0; dresp_valid = 1'b0; resp_ready = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          beats;
        bit          got;
        logic [63:0] a [2];
        a[0] = 64'h0; a[1] = 64'h0;
        sel = v.dut;
        do_reset();
        resp_ready = 1'b1;
        req_valid = 1'b1; req_addr = v.addr; req_msize = v.msize; req_unsigned = v.uns;
        tick();
        req_valid = 1'b0;
        beats = 0;
        got = 1'b0;
        for (int cyc = 0; cyc < 20 && !got; cyc++) begin
            dresp_valid = 1'b0;
            if (s_resp_valid) begin
                got = 1'b1;
                chk($sformatf("v%0d_data", idx), s_resp_data, v.exp_data);
                chk($sformatf("v%0d_split", idx), 64'(s_resp_split), 64'(v.exp_split));
                chk($sformatf("v%0d_err", idx), 64'(s_resp_err), 64'(v.exp_err));
                chk($sformatf("v%0d_dreq_quiet", idx), 64'(s_dreq_valid), 64'h0);
            end else if (s_dreq_valid) begin
                if (beats < 2) a[beats] = s_dreq_addr;
                dresp_valid = 1'b1;
                dresp_data  = (beats == 0) ? v.b0 : v.b1;
                beats++;
            end
            if (!got) tick();
        end
        dresp_valid = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL v%0d_timeout actual=no_resp required=resp_valid", idx);
        end
        chk($sformatf("v%0d_beats", idx), 64'(beats), 64'(v.exp_beats));
        if (v.exp_beats >= 1) chk($sformatf("v%0d_addr0", idx), a[0], v.exp_a0);
        if (v.exp_beats >= 2) chk($sformatf("v%0d_addr1", idx), a[1], v.exp_a1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; sel = 0;
        reset = 1'b1; req_valid = 1'b0; req_addr = 64'h0; req_msize = MSIZE1;
        req_unsigned = 1'b0; dresp_valid = 1'b0; dresp_data = 64'h0; resp_ready = 1'b0;

        //           dut size    addr                    uns   b0                      b1                      exp_data                 spl   err   nb a0                      a1
        vecs[0]  = '{0, MSIZE1, 64'h1003,               1'b0, 64'h1122_3344_8566_7788, 64'h0,                  64'hFFFF_FFFF_FFFF_FF85, 1'b0, 1'b0, 1, 64'h1000,               64'h0};
        vecs[1]  = '{0, MSIZE1, 64'h1003,               1'b1, 64'h1122_3344_8566_7788, 64'h0,                  64'h85,                  1'b0, 1'b0, 1, 64'h1000,               64'h0};
        vecs[2]  = '{0, MSIZE4, 64'h2006,               1'b0, 64'hAABB_0000_0000_0000, 64'h0000_0000_0000_CCDD, 64'hFFFF_FFFF_CCDD_AABB, 1'b1, 1'b0, 2, 64'h2000,               64'h2008};
        vecs[3]  = '{1, MSIZE8, 64'h3004,               1'b0, 64'h0,                  64'h0,                  64'h0,                   1'b0, 1'b1, 0, 64'h0,                  64'h0};
        vecs[4]  = '{0, MSIZE2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h3400_0000_0000_0000, 64'h92,                 64'hFFFF_FFFF_FFFF_9234, 1'b1, 1'b0, 2, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0};
        vecs[5]  = '{2, MSIZE8, 64'h40,                 1'b0, 64'h0,                  64'h0,                  64'h0,                   1'b0, 1'b1, 0, 64'h0,                  64'h0};
        vecs[6]  = '{2, MSIZE4, 64'h104,                1'b1, 64'h8000_0001,          64'h0,                  64'h8000_0001,           1'b0, 1'b0, 1, 64'h104,                64'h0};
        vecs[7]  = '{2, MSIZE4, 64'h104,                1'b0, 64'h8000_0001,          64'h0,                  64'h8000_0001,           1'b0, 1'b0, 1, 64'h104,                64'h0};
        vecs[8]  = '{2, MSIZE2, 64'h203,                1'b0, 64'hAB00_0000,          64'hCD,                 64'hFFFF_CDAB,           1'b1, 1'b0, 2, 64'h200,                64'h204};
        vecs[9]  = '{0, MSIZE8, 64'h5000,               1'b1, 64'h8123_4567_89AB_CDEF, 64'h0,                  64'h8123_4567_89AB_CDEF, 1'b0, 1'b0, 1, 64'h5000,               64'h0};
        vecs[10] = '{0, MSIZE4, 64'h5004,               1'b1, 64'h8765_4321_0000_0000, 64'h0,                  64'h8765_4321,           1'b0, 1'b0, 1, 64'h5000,               64'h0};
        vecs[11] = '{1, MSIZE2, 64'h6007,               1'b0, 64'h0,                  64'h0,                  64'h0,                   1'b0, 1'b1, 0, 64'h0,                  64'h0};
        vecs[12] = '{1, MSIZE1, 64'h6007,               1'b1, 64'hF100_0000_0000_0000, 64'h0,                  64'hF1,                  1'b0, 1'b0, 1, 64'h6000,               64'h0};
        vecs[13] = '{2, MSIZE1, 64'h7002,               1'b0, 64'h0070_0000,          64'h0,                  64'h70,                  1'b0, 1'b0, 1, 64'h7000,               64'h0};
        vecs[14] = '{0, MSIZE2, 64'h8006,               1'b0, 64'hFFEE_0000_0000_0000, 64'h0,                  64'hFFFF_FFFF_FFFF_FFEE, 1'b0, 1'b0, 1, 64'h8000,               64'h0};

        // Reset state.
        #1;
        chk("rst_req_ready", 64'(a_req_ready), 64'h0);
        chk("rst_dreq_valid", 64'(a_dreq_valid), 64'h0);
        chk("rst_resp_valid", 64'(a_resp_valid), 64'h0);
        chk("rst_resp_data", a_resp_data, 64'h0);
        tick();
        reset = 1'b0;
        tick();
        chk("rst_release_ready", 64'(a_req_ready), 64'h1);

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // Latency of an aligned load with immediate bus response.
        sel = 0;
        do_reset();
        resp_ready = 1'b1;
        chk("lat_c0_ready", 64'(s_req_ready), 64'h1);
        req_valid = 1'b1; req_addr = 64'h1003; req_msize = MSIZE1; req_unsigned = 1'b0;
        tick();
        req_valid = 1'b0;
        chk("lat_c1_dreq", 64'(s_dreq_valid), 64'h1);
        chk("lat_c1_resp", 64'(s_resp_valid), 64'h0);
        chk("lat_c1_ready", 64'(s_req_ready), 64'h0);
        dresp_valid = 1'b1; dresp_data = 64'h1122_3344_8566_7788;
        tick();
        dresp_valid = 1'b0;
        chk("lat_c2_resp", 64'(s_resp_valid), 64'h1);
        chk("lat_c2_dreq", 64'(s_dreq_valid), 64'h0);
        chk("lat_c2_data", s_resp_data, 64'hFFFF_FFFF_FFFF_FF85);
        tick();
        chk("lat_c3_ready", 64'(s_req_ready), 64'h1);
        chk("lat_c3_resp", 64'(s_resp_valid), 64'h0);

        // Rejected misaligned doubleword: no bus traffic, error held under backpressure.
        sel = 1;
        do_reset();
        resp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 64'h3004; req_msize = MSIZE8; req_unsigned = 1'b0;
        tick();
        req_valid = 1'b0;
        chk("err_c1_resp", 64'(s_resp_valid), 64'h1);
        chk("err_c1_err", 64'(s_resp_err), 64'h1);
        chk("err_c1_dreq", 64'(s_dreq_valid), 64'h0);
        tick();
        chk("err_c2_resp", 64'(s_resp_valid), 64'h1);
        chk("err_c2_err", 64'(s_resp_err), 64'h1);
        chk("err_c2_data", s_resp_data, 64'h0);
        chk("err_c2_split", 64'(s_resp_split), 64'h0);
        chk("err_c2_dreq", 64'(s_dreq_valid), 64'h0);
        resp_ready = 1'b1;
        tick();
        chk("err_c3_ready", 64'(s_req_ready), 64'h1);
        chk("err_c3_resp", 64'(s_resp_valid), 64'h0);

        // Backpressure on a split load with a second request waiting.
        sel = 0;
        do_reset();
        resp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 64'h2006; req_msize = MSIZE4; req_unsigned = 1'b0;
        tick();
        req_addr = 64'h1003; req_msize = MSIZE1; req_unsigned = 1'b1;
        for (int b = 0; b < 2; b++) begin
            chk($sformatf("bp_beat%0d_dreq", b), 64'(s_dreq_valid), 64'h1);
            dresp_valid = 1'b1;
            dresp_data  = (b == 0) ? 64'hAABB_0000_0000_0000 : 64'h0000_0000_0000_CCDD;
            tick();
        end
        dresp_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d_resp", k), 64'(s_resp_valid), 64'h1);
            chk($sformatf("bp%0d_data", k), s_resp_data, 64'hFFFF_FFFF_CCDD_AABB);
            chk($sformatf("bp%0d_split", k), 64'(s_resp_split), 64'h1);
            chk($sformatf("bp%0d_err", k), 64'(s_resp_err), 64'h0);
            chk($sformatf("bp%0d_ready", k), 64'(s_req_ready), 64'h0);
            chk($sformatf("bp%0d_dreq", k), 64'(s_dreq_valid), 64'h0);
            tick();
        end
        resp_ready = 1'b1;
        chk("bp_hs_data", s_resp_data, 64'hFFFF_FFFF_CCDD_AABB);
        tick();
        chk("bp_after_ready", 64'(s_req_ready), 64'h1);
        chk("bp_after_resp", 64'(s_resp_valid), 64'h0);
        chk("bp_after_dreq", 64'(s_dreq_valid), 64'h0);
        tick();
        req_valid = 1'b0;
        chk("bp_2nd_dreq", 64'(s_dreq_valid), 64'h1);
        chk("bp_2nd_addr", s_dreq_addr, 64'h1000);
        dresp_valid = 1'b1; dresp_data = 64'h1122_3344_8566_7788;
        tick();
        dresp_valid = 1'b0;
        chk("bp_2nd_resp", 64'(s_resp_valid), 64'h1);
        chk("bp_2nd_data", s_resp_data, 64'h85);
        tick();

        // 32-bit instance: reset during the second beat, then a stray bus pulse.
        sel = 2;
        do_reset();
        resp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 64'h203; req_msize = MSIZE2; req_unsigned = 1'b0;
        tick();
        req_valid = 1'b0;
        chk("rb_beat0_addr", s_dreq_addr, 64'h200);
        dresp_valid = 1'b1; dresp_data = 64'hAB00_0000;
        tick();
        dresp_valid = 1'b0;
        chk("rb_beat1_dreq", 64'(s_dreq_valid), 64'h1);
        chk("rb_beat1_addr", s_dreq_addr, 64'h204);
        #2;
        reset = 1'b1;
        #1;
        chk("rb_req_ready", 64'(c_req_ready), 64'h0);
        chk("rb_dreq_valid", 64'(c_dreq_valid), 64'h0);
        chk("rb_dreq_addr", c_dreq_addr, 64'h0);
        chk("rb_resp_valid", 64'(c_resp_valid), 64'h0);
        chk("rb_resp_data", 64'(c_resp_data), 64'h0);
        chk("rb_resp_split", 64'(c_resp_split), 64'h0);
        chk("rb_resp_err", 64'(c_resp_err), 64'h0);
        tick();
        reset = 1'b0;
        dresp_valid = 1'b1; dresp_data = 64'hCD;
        tick();
        dresp_valid = 1'b0;
        chk("rb_stray_ready", 64'(s_req_ready), 64'h1);
        chk("rb_stray_resp", 64'(s_resp_valid), 64'h0);
        chk("rb_stray_dreq", 64'(s_dreq_valid), 64'h0);
        tick();
        chk("rb_stray2_resp", 64'(s_resp_valid), 64'h0);
        chk("rb_stray2_ready", 64'(s_req_ready), 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
Sequential successor to the combinational load-data extractor in the memory stage. Accepts one load request at a time and issues one or two aligned reads to the data bus. A second read is issued when the access crosses a word boundary. The unit merges the beats, then extracts and sign/zero-extends the addressed field, and returns the result through a valid/ready handshake. It is generalised in data width and adds a misaligned-access mode.

Parameters:
DATA_W, 64, bus and result width in bits; legal values 32 or 64; BYTES = DATA_W/8, OFF_W = log2(BYTES)
ADDR_W, 64, address width
ALLOW_MISALIGN, 1, 1 = split boundary-crossing loads into two beats; 0 = reject them with resp_err

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  load request valid
req_ready  out  1  unit can accept a request
req_addr  in  ADDR_W  byte address
req_msize  in  msize_t  MSIZE1/2/4/8 (from common)
req_unsigned  in  1  1 = zero-extend (LBU/LHU/LWU)
dreq_valid  out  1  bus read request
dreq_addr  out  ADDR_W  word-aligned address (low OFF_W bits zero)
dresp_valid  in  1  one-cycle pulse: bus data valid
dresp_data  in  DATA_W  aligned bus word
resp_valid  out  1  result valid
resp_ready  in  1  consumer accepts result
resp_data  out  DATA_W  extended load result
resp_split  out  1  result needed two beats
resp_err  out  1  illegal access (no bus traffic occurred)

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high; it forces state IDLE and drives every output and internal register to 0.
- Reset mid-operation: the in-flight request is abandoned. Any dresp_valid arriving after reset deasserts while in IDLE is ignored.
- States: IDLE, BEAT0, BEAT1, DONE.
- req_ready is 1 only in IDLE.
- Request capture (IDLE, req_valid=1): latch addr, msize, unsigned. Compute:
  - n = size in bytes
  - off = addr[OFF_W-1:0]
  - cross = (off + n > BYTES)
- Error checks at capture, in priority order:
  - msize = MSIZE8 with DATA_W = 32 -> resp_err=1, go directly to DONE.
  - cross=1 with ALLOW_MISALIGN=0 -> resp_err=1, go directly to DONE.
  - Otherwise go to BEAT0.
- BEAT0:
  - dreq_valid=1, dreq_addr = addr with low OFF_W bits cleared.
  - Both are held stable until dresp_valid. On dresp_valid, store beat0.
  - Next state: BEAT1 if cross=1, else DONE.
- BEAT1:
  - dreq_valid=1, dreq_addr = aligned addr + BYTES, modulo 2^ADDR_W (wraps to 0 at the top of the address space).
  - On dresp_valid, store beat1 and go to DONE.
- dreq_valid is registered and drops in the cycle after dresp_valid is sampled. dreq_valid and resp_valid are never both 1.
- Merge and extend:
  - word = {beat1, beat0} >> (off*8), zero-width beat1 = 0 when cross=0.
  - Field = low n bytes of word.
  - Sign bit = field MSB unless req_unsigned=1, in which case it is 0.
  - resp_data = sign bit replicated to DATA_W ++ field.
  - MSIZE8 (or MSIZE4 when DATA_W=32) with req_unsigned=1 is identical to the signed result.
- DONE:
  - resp_valid=1; resp_data, resp_split (= cross), and resp_err are held stable while resp_ready=0.
  - When resp_ready=1, go to IDLE and clear resp_valid in the next cycle.
  - On error, resp_data=0 and resp_split=0.
- Latency: aligned load with immediate bus response and resp_ready=1:
  - request accepted cycle 0
  - dreq_valid in cycle 1
  - dresp_valid in cycle 1
  - resp_valid in cycle 2
  - req_ready again in cycle 3
  - A split load adds one cycle per extra beat plus the bus wait.
- Throughput: no new request is accepted until the current response handshakes. There is no back-to-back overlap.
- dresp_valid seen in IDLE or DONE is ignored.

Test Plan:
- DATA_W=64: LB at addr 0x1003, beat data 0x1122_3344_8566_7788 -> resp_data=0xFFFF_FFFF_FFFF_FF85, resp_split=0. The same request with req_unsigned=1 -> 0x85.
- DATA_W=64, ALLOW_MISALIGN=1: LW at addr 0x2006, beat0=0xAABB_0000_0000_0000, beat1=0x0000_0000_0000_CCDD:
  - dreq_addr=0x2000, then 0x2008
  - resp_data=0xFFFF_FFFF_CCDD_AABB, resp_split=1
- ALLOW_MISALIGN=0: LD at 0x3004 -> no dreq_valid pulse, resp_err=1, resp_data=0 in cycle 2.
- Backpressure: hold resp_ready=0 for 5 cycles, then 1 -> resp_* stable throughout, req_ready asserts exactly one cycle after the handshake. A second req_valid held during this window is accepted only then.
- Wrap: split LH at addr 0xFFFF_FFFF_FFFF_FFFF -> second dreq_addr=0x0.
- DATA_W=32 checks:
  - LD -> resp_err=1.
  - Reset asserted during BEAT1 -> all outputs 0 asynchronously.
  - A dresp_valid pulse after reset releases -> ignored, req_ready=1.
